// File: rtl/tone_sequencer_pkg.sv
// Shared types for the tone sequencer: FSM states and the note table entry layout.
package tone_sequencer_pkg;

  localparam int unsigned TS_NUM_NOTES  = 16;
  localparam int unsigned TS_RATE_WIDTH = 11;
  localparam int unsigned TS_DUR_WIDTH  = 16;
  localparam int unsigned IDX_WIDTH     = $clog2(TS_NUM_NOTES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_GAP
  } state_e;

  typedef struct packed {
    logic [TS_RATE_WIDTH-1:0] rate;
    logic [TS_DUR_WIDTH-1:0]  duration;
    logic                     last;
  } note_entry_t;

endpackage

// File: rtl/tone_sequencer_table.sv
// Note table RAM: one write port, one registered read port with read-first behaviour.
module tone_table
  import tone_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  note_entry_t       wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output note_entry_t       rdata_o
);

  note_entry_t mem_q [DEPTH];
  note_entry_t rdata_q;

  // Same-edge write and read to one address returns the old entry.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tone_sequencer.sv
// Steps through the note table, driving the sawtooth rate/enable with silent gaps
// between notes and optional looping.
module tone_sequencer
  import tone_sequencer_pkg::*;
#(
  parameter int unsigned NUM_NOTES   = TS_NUM_NOTES,
  parameter int unsigned DUR_WIDTH   = TS_DUR_WIDTH,
  parameter int unsigned GAP_SAMPLES = 480,
  parameter int unsigned RATE_WIDTH  = TS_RATE_WIDTH
) (
  input  logic                         clk_audio,
  input  logic                         reset,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_NOTES)-1:0] cfg_addr,
  input  logic [RATE_WIDTH-1:0]        cfg_rate,
  input  logic [DUR_WIDTH-1:0]         cfg_duration,
  input  logic                         cfg_last,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         loop,
  output logic [RATE_WIDTH-1:0]        wave_rate,
  output logic                         enable,
  output logic                         busy,
  output logic [$clog2(NUM_NOTES)-1:0] note_index,
  output logic                         done
);

  localparam int unsigned AW = $clog2(NUM_NOTES);
  localparam int unsigned GW = (GAP_SAMPLES > 0) ? $clog2(GAP_SAMPLES + 1) : 1;
  localparam logic [GW-1:0]         GAP_LOAD = GW'(GAP_SAMPLES);
  localparam logic [GW-1:0]         GAP_ONE  = GW'(1);
  localparam logic [DUR_WIDTH-1:0]  DUR_ONE  = DUR_WIDTH'(1);
  localparam logic [AW-1:0]         IDX_MAX  = AW'(NUM_NOTES - 1);

  state_e                state_q, state_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic [DUR_WIDTH-1:0]  dur_q, dur_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [RATE_WIDTH-1:0] rate_q, rate_d;
  logic                  en_q, en_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  last_q, last_d;
  logic                  tbl_end;
  note_entry_t           wr_entry, rd_entry;

  assign wr_entry = '{rate: cfg_rate, duration: cfg_duration, last: cfg_last};

  // The read address follows the next index so the entry is ready during LOAD.
  tone_table #(
    .DEPTH (NUM_NOTES),
    .AW    (AW)
  ) u_table (
    .clk_i   (clk_audio),
    .we_i    (cfg_we),
    .waddr_i (cfg_addr),
    .wdata_i (wr_entry),
    .raddr_i (idx_d),
    .rdata_o (rd_entry)
  );

  assign tbl_end = last_q || (idx_q == IDX_MAX);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dur_d   = dur_q;
    gap_d   = gap_q;
    rate_d  = rate_q;
    en_d    = en_q;
    done_d  = 1'b0;
    last_d  = last_q;

    if (stop && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      en_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          en_d = 1'b0;
          if (start && !stop) begin
            state_d = ST_LOAD;
            idx_d   = '0;
          end
        end
        ST_LOAD: begin
          dur_d  = (rd_entry.duration == '0) ? DUR_ONE : rd_entry.duration;
          last_d = rd_entry.last;
          en_d   = (rd_entry.rate != '0);
          if (rd_entry.rate != '0) rate_d = rd_entry.rate;
          state_d = ST_PLAY;
        end
        ST_PLAY: begin
          if (dur_q == DUR_ONE) begin
            en_d = 1'b0;
            if (tbl_end && !loop) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              idx_d = tbl_end ? '0 : idx_q + AW'(1);
              if (GAP_SAMPLES == 0) begin
                state_d = ST_LOAD;
              end else begin
                state_d = ST_GAP;
                gap_d   = GAP_LOAD;
              end
            end
          end else begin
            dur_d = dur_q - DUR_ONE;
          end
        end
        ST_GAP: begin
          en_d = 1'b0;
          if (gap_q <= GAP_ONE) state_d = ST_LOAD;
          else                  gap_d   = gap_q - GAP_ONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_audio) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      dur_q   <= '0;
      gap_q   <= '0;
      rate_q  <= RATE_WIDTH'(1);
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dur_q   <= dur_d;
      gap_q   <= gap_d;
      rate_q  <= rate_d;
      en_q    <= en_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
    end
  end

  assign wave_rate  = rate_q;
  assign enable     = en_q;
  assign busy       = busy_q;
  assign note_index = idx_q;
  assign done       = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Randomized bench for tone_sequencer: expected per-cycle traces are built from the
// note table by walking LOAD / note / gap phases in plain arithmetic.
module tb_tone_sequencer;

  localparam int NN  = 16;
  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        reset, cfg_we, cfg_last, start, stop, loop;
  logic [3:0]  cfg_addr;
  logic [10:0] cfg_rate;
  logic [15:0] cfg_duration;
  logic [10:0] wave_rate;
  logic        enable, busy, done;
  logic [3:0]  note_index;

  tone_sequencer #(
    .NUM_NOTES   (NN),
    .DUR_WIDTH   (16),
    .GAP_SAMPLES (GAP),
    .RATE_WIDTH  (11)
  ) dut (
    .clk_audio    (clk),
    .reset        (reset),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_rate     (cfg_rate),
    .cfg_duration (cfg_duration),
    .cfg_last     (cfg_last),
    .start        (start),
    .stop         (stop),
    .loop         (loop),
    .wave_rate    (wave_rate),
    .enable       (enable),
    .busy         (busy),
    .note_index   (note_index),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int en;
    int rate;
    int busy;
    int done;
    int idx;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_rate [NN];
  int   m_dur  [NN];
  int   m_last [NN];
  int   model_rate = 1;
  exp_t tr[$];

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check_eq({tag, ".enable"}, enable, e.en);
    check_eq({tag, ".wave_rate"}, wave_rate, e.rate);
    check_eq({tag, ".busy"}, busy, e.busy);
    check_eq({tag, ".done"}, done, e.done);
    check_eq({tag, ".note_index"}, note_index, e.idx);
    check_eq({tag, ".rate_nonzero"}, (wave_rate != 0), 1);
  endtask

  task automatic write_note(input int i, input int rate, input int dur, input int last);
    cfg_we = 1'b1; cfg_addr = 4'(i); cfg_rate = 11'(rate);
    cfg_duration = 16'(dur); cfg_last = 1'(last);
    step();
    cfg_we = 1'b0;
    m_rate[i] = rate; m_dur[i] = dur; m_last[i] = last;
  endtask

  // Builds the expected trace from the cycle after start is sampled; returns the
  // cycle index at which the second pass begins (-1 if none).
  function automatic int build_trace(input int passes);
    int r = model_rate;
    int i = 0;
    int p = 0;
    int pass2 = -1;
    int d, nxt;
    bit fin;
    tr.delete();
    for (int guard = 0; guard < 4 * NN; guard++) begin
      tr.push_back('{0, r, 1, 0, i});
      if (m_rate[i] != 0) r = m_rate[i];
      d = (m_dur[i] == 0) ? 1 : m_dur[i];
      for (int k = 0; k < d; k++) tr.push_back('{(m_rate[i] != 0), r, 1, 0, i});
      fin = (m_last[i] != 0) || (i == NN - 1);
      if (fin && p == passes - 1) begin
        tr.push_back('{0, r, 0, 1, i});
        tr.push_back('{0, r, 0, 0, i});
        tr.push_back('{0, r, 0, 0, i});
        break;
      end
      nxt = fin ? 0 : i + 1;
      for (int k = 0; k < GAP; k++) tr.push_back('{0, r, 1, 0, nxt});
      if (fin) begin
        p++;
        pass2 = tr.size();
      end
      i = nxt;
    end
    return pass2;
  endfunction

  task automatic play_run(input string tag, input int passes, input int stop_at, input int reset_at);
    int pass2;
    pass2 = build_trace(passes);
    loop  = (passes > 1);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < tr.size(); c++) begin
      check_outputs(tag, tr[c]);
      if (c == pass2) loop = 1'b0;
      if (c == stop_at) begin
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_outputs({tag, ".stop"}, '{0, tr[c].rate, 0, 0, tr[c].idx});
        model_rate = tr[c].rate;
        loop = 1'b0;
        return;
      end
      if (c == reset_at) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_outputs({tag, ".reset"}, '{0, 1, 0, 0, 0});
        model_rate = 1;
        loop = 1'b0;
        return;
      end
      step();
    end
    model_rate = tr[tr.size() - 1].rate;
    loop = 1'b0;
  endtask

  initial begin
    int n, last_at, st;
    reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_rate = '0; cfg_duration = '0;
    cfg_last = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
    for (int i = 0; i < NN; i++) begin m_rate[i] = 0; m_dur[i] = 0; m_last[i] = 0; end
    step(); step();
    reset = 1'b0;
    check_outputs("reset", '{0, 1, 0, 0, 0});

    // Single note, no loop
    write_note(0, 440, 4, 1);
    play_run("single", 1, -1, -1);

    // Note, rest, note
    write_note(0, 440, 3, 0);
    write_note(1, 0, 2, 0);
    write_note(2, 880, 3, 1);
    play_run("rest", 1, -1, -1);

    // Loop once, dropped during the second pass
    play_run("loop", 2, -1, -1);

    // Stop in the second play cycle of a long note
    write_note(0, 440, 10, 1);
    play_run("stop", 1, 2, -1);

    // Start and stop together from idle
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check_outputs("startstop", '{0, model_rate, 0, 0, 0});
    step();
    check_outputs("startstop2", '{0, model_rate, 0, 0, 0});

    // Zero duration plays one sample
    write_note(0, 300, 0, 1);
    play_run("dur0", 1, -1, -1);

    // No last flag anywhere: table end terminates
    for (int i = 0; i < NN; i++) write_note(i, 100 + i, 1 + (i % 2), 0);
    play_run("full", 1, -1, -1);

    // Reset during the first gap, then replay from surviving table
    write_note(0, 440, 3, 0);
    write_note(1, 0, 2, 0);
    write_note(2, 880, 3, 1);
    play_run("rstgap", 1, -1, 4);
    play_run("replay", 1, -1, -1);

    // Random tables
    for (int run = 0; run < 20; run++) begin
      last_at = $urandom_range(0, NN - 1);
      for (int i = 0; i < NN; i++)
        write_note(i, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 2047),
                   $urandom_range(0, 4),
                   ((i == last_at) && ($urandom_range(0, 3) != 0)) ? 1 : 0);
      n = $urandom_range(1, 2);
      void'(build_trace(n));
      st = ($urandom_range(0, 2) == 0) ? $urandom_range(0, tr.size() - 4) : -1;
      play_run("rand", n, st, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
